// File: rtl/prime_decision_sequencer.sv
// prime_decision_sequencer: accepts an unsigned operand, streams it MSB-first
// through serial residue trackers for 3, 5, 7, 11 and 13, then registers a
// prime/not-prime verdict plus a per-divisor hit mask on an output handshake.
module prime_decision_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_prime,
   output logic [5:0]       out_div_mask
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_DECIDE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Last SHIFT edge index: the counter runs 0..WIDTH-1 while shifting.
   localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       r3_q, r3_d;
   logic [2:0]       r5_q, r5_d;
   logic [2:0]       r7_q, r7_d;
   logic [3:0]       r11_q, r11_d;
   logic [3:0]       r13_q, r13_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_prime_q, out_prime_d;
   logic [5:0]       out_mask_q, out_mask_d;

   logic             msb_s;
   logic [5:0]       mask_s;
   logic             prime_s;

   assign msb_s = shreg_q[WIDTH-1];

   // Verdict from the final residues: a hit disqualifies unless n is the divisor itself.
   always_comb begin
      mask_s[0] = ~opnd_q[0];
      mask_s[1] = (r3_q  == 2'd0);
      mask_s[2] = (r5_q  == 3'd0);
      mask_s[3] = (r7_q  == 3'd0);
      mask_s[4] = (r11_q == 4'd0);
      mask_s[5] = (r13_q == 4'd0);
      prime_s   = (opnd_q >= WIDTH'(2))
                & (~mask_s[0] | (opnd_q == WIDTH'(2)))
                & (~mask_s[1] | (opnd_q == WIDTH'(3)))
                & (~mask_s[2] | (opnd_q == WIDTH'(5)))
                & (~mask_s[3] | (opnd_q == WIDTH'(7)))
                & (~mask_s[4] | (opnd_q == WIDTH'(11)))
                & (~mask_s[5] | (opnd_q == WIDTH'(13)));
   end

   // Next-state, datapath and output-register logic for the sequencer FSM.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      opnd_d      = opnd_q;
      cnt_d       = cnt_q;
      r3_d        = r3_q;
      r5_d        = r5_q;
      r7_d        = r7_q;
      r11_d       = r11_q;
      r13_d       = r13_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_prime_d = out_prime_q;
      out_mask_d  = out_mask_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               shreg_d = in_data;
               opnd_d  = in_data;
               cnt_d   = 4'd0;
               r3_d    = 2'd0;
               r5_d    = 3'd0;
               r7_d    = 3'd0;
               r11_d   = 4'd0;
               r13_d   = 4'd0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // r <= (2r + bit) mod d; since r < d, 2r+bit < 2d so one subtract
            // suffices, and the result always fits the residue width.
            r3_d  = ({r3_q, msb_s}  >= 3'd3)  ? ({r3_q[0], msb_s}    - 2'd3)  : {r3_q[0], msb_s};
            r5_d  = ({r5_q, msb_s}  >= 4'd5)  ? ({r5_q[1:0], msb_s}  - 3'd5)  : {r5_q[1:0], msb_s};
            r7_d  = ({r7_q, msb_s}  >= 4'd7)  ? ({r7_q[1:0], msb_s}  - 3'd7)  : {r7_q[1:0], msb_s};
            r11_d = ({r11_q, msb_s} >= 5'd11) ? ({r11_q[2:0], msb_s} - 4'd11) : {r11_q[2:0], msb_s};
            r13_d = ({r13_q, msb_s} >= 5'd13) ? ({r13_q[2:0], msb_s} - 4'd13) : {r13_q[2:0], msb_s};
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DECIDE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DECIDE: begin
            out_valid_d = 1'b1;
            out_data_d  = opnd_q;
            out_prime_d = prime_s;
            out_mask_d  = mask_s;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; synchronous reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         opnd_q      <= '0;
         cnt_q       <= 4'd0;
         r3_q        <= 2'd0;
         r5_q        <= 3'd0;
         r7_q        <= 3'd0;
         r11_q       <= 4'd0;
         r13_q       <= 4'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_prime_q <= 1'b0;
         out_mask_q  <= 6'd0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         opnd_q      <= opnd_d;
         cnt_q       <= cnt_d;
         r3_q        <= r3_d;
         r5_q        <= r5_d;
         r7_q        <= r7_d;
         r11_q       <= r11_d;
         r13_q       <= r13_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_prime_q <= out_prime_d;
         out_mask_q  <= out_mask_d;
      end
   end

   assign in_ready     = (state_q == ST_IDLE);
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_prime    = out_prime_q;
   assign out_div_mask = out_mask_q;

endmodule

// File: tb/tb_prime_decision_sequencer.sv
// Self-checking bench for prime_decision_sequencer: directed operands, latency
// and backpressure, resets, and a full 0..255 sweep with random gaps and
// backpressure against a trial-division reference model.
module tb_prime_decision_sequencer;

   localparam int WIDTH = 8;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_prime;
   logic [5:0]       out_div_mask;

   int checks = 0;
   int errors = 0;

   prime_decision_sequencer #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_prime    (out_prime),
      .out_div_mask (out_div_mask)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: true primality by trial division over every smaller integer.
   function automatic int ref_prime(input int n);
      if (n < 2) return 0;
      for (int i = 2; i < n; i++) begin
         if (n % i == 0) return 0;
      end
      return 1;
   endfunction

   // Reference: plain divisibility by 2, 3, 5, 7, 11, 13.
   function automatic int ref_mask(input int n);
      int dv[6];
      int m;
      dv = '{2, 3, 5, 7, 11, 13};
      m = 0;
      for (int k = 0; k < 6; k++) begin
         if (n % dv[k] == 0) m = m | (1 << k);
      end
      return m;
   endfunction

   // One full transaction: offer n, measure latency, check verdict, apply bp
   // cycles of backpressure (with in_valid noise), then release.
   task automatic run_op(input int n, input int bp, input int exp_prime, input int exp_mask);
      int lat;
      int waited;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("in_ready_before_offer", int'(in_ready), 1);
      in_valid  = 1'b1;
      in_data   = WIDTH'(n);
      out_ready = (bp == 0);
      @(posedge clk); #1;                 // accepting edge E0
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      lat = 0;
      for (int k = 1; k <= WIDTH + 6; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            break;
         end
         chk("in_ready_low_busy", int'(in_ready), 0);
      end
      chk("latency", lat, WIDTH + 1);
      chk("out_data", int'(out_data), n);
      chk("out_prime", int'(out_prime), exp_prime);
      chk("out_div_mask", int'(out_div_mask), exp_mask);
      chk("in_ready_done", int'(in_ready), 0);
      if (bp > 0) begin
         for (int c = 0; c < bp; c++) begin
            in_valid = 1'($urandom);
            in_data  = WIDTH'($urandom);
            @(posedge clk); #1;
            chk("bp_valid_held", int'(out_valid), 1);
            chk("bp_data_held", int'(out_data), n);
            chk("bp_prime_held", int'(out_prime), exp_prime);
            chk("bp_mask_held", int'(out_div_mask), exp_mask);
            chk("bp_in_ready_low", int'(in_ready), 0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("release_valid_low", int'(out_valid), 0);
      chk("release_in_ready", int'(in_ready), 1);
      chk("verdict_kept_prime", int'(out_prime), exp_prime);
      chk("verdict_kept_mask", int'(out_div_mask), exp_mask);
   endtask

   initial begin
      int seen;
      int gap;
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'd5;
      out_ready = 1'b1;

      // Reset held two cycles with in_valid offered: reset must win.
      @(posedge clk); @(posedge clk); #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_prime", int'(out_prime), 0);
      chk("rst_out_mask", int'(out_div_mask), 0);
      chk("rst_out_data", int'(out_data), 0);

      // Directed operands from the boundary table.
      run_op(0,   0, 0, 6'b111111);
      run_op(1,   0, 0, 6'b000000);
      run_op(2,   0, 1, 6'b000001);
      run_op(13,  0, 1, 6'b100000);
      run_op(251, 0, 1, 6'b000000);
      run_op(169, 0, 0, 6'b100000);
      run_op(143, 0, 0, 6'b110000);
      run_op(255, 0, 0, 6'b000110);

      // Latency and 5 cycles of backpressure on a prime.
      run_op(211, 5, 1, 6'b000000);

      // Reset two cycles while mid-SHIFT, then while holding a verdict.
      in_valid = 1'b1;
      in_data  = 8'd97;
      @(posedge clk); #1;                 // E0
      in_valid = 1'b0;
      repeat (4) @(posedge clk);          // E1..E4
      #1 reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      chk("midshift_rst_in_ready", int'(in_ready), 1);
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("midshift_no_verdict", seen, 0);
      // 91 = 7 * 13, so both the 7 and 13 trackers hit.
      run_op(91, 0, 0, 6'b101000);

      // Exhaustive sweep with random idle gaps and random backpressure.
      for (int n = 0; n < 256; n++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            in_data = WIDTH'($urandom);
            @(posedge clk); #1;
         end
         run_op(n, int'($urandom_range(0, 3)), ref_prime(n), ref_mask(n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
